// File: rtl/seg_scan_drv_pkg.sv
// seg_scan_drv_pkg: shared display constants and the leading-digit helper
package seg_scan_drv_pkg;
   localparam int SEG_NDIGIT = 8;
   localparam int SEG_IDX_NBIT = 3;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] SEG_AN_OFF = 8'hFF;
   // index of the most-significant nonzero nibble; 0 when the word is zero
   function automatic logic [SEG_IDX_NBIT-1:0] msd(input logic [31:0] v);
      msd = '0;
      for (int i = 1; i < SEG_NDIGIT; i++)
         if (v[4*i +: 4] != 4'd0) msd = SEG_IDX_NBIT'(i);
   endfunction
endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: 4-bit hex to active-low {g,f,e,d,c,b,a} segment decoder
module seg_hex_dec (
   input  logic [3:0] val,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h7F;
      case (val)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end
endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: 8-digit multiplexed seven-segment driver with sticky halt freeze.
// Define SEG_LEAD_BLANK_EN to blank digits above the most-significant nonzero nibble.
module seg_scan_drv
   import seg_scan_drv_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] display,
   input  logic        halt,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  an_n
);
   localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   logic [CW-1:0] cnt;
   logic [SEG_IDX_NBIT-1:0] idx;
   logic [31:0] disp_q;
   logic halt_q;
   logic [3:0] nib;
   logic [6:0] seg;
   logic blank;
   assign nib = disp_q[4*idx +: 4];
   seg_hex_dec u_dec (.val(nib), .seg(seg));
`ifdef SEG_LEAD_BLANK_EN
   assign blank = idx > msd(disp_q);
`else
   assign blank = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         disp_q <= '0;
         halt_q <= 1'b0;
         an_n <= SEG_AN_OFF;
         seg_n <= SEG_BLANK;
         dp_n <= 1'b1;
      end else begin
         // gate uses the pre-update halt_q so a same-cycle halt still captures
         if (en && !halt_q) disp_q <= display;
         if (halt) halt_q <= 1'b1;
         if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         an_n <= blank ? SEG_AN_OFF : ~(8'd1 << idx);
         seg_n <= blank ? SEG_BLANK : seg;
         dp_n <= blank | ~halt_q;
      end
   end
endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: randomized and directed checks against a slot-arithmetic reference model
module tb_seg_scan_drv;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic [31:0] display = '0;
   logic halt = 1'b0;
   logic [6:0] seg_n;
   logic dp_n;
   logic [7:0] an_n;
   int errors = 0;
   int checks = 0;
   int k = 0;
   logic [31:0] disp_m = '0;
   logic halt_m = 1'b0;
   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_drv #(.SCAN_DIV(D)) dut (
      .clk(clk), .rst(rst), .en(en), .display(display), .halt(halt),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int top_nz(input logic [31:0] v);
      int m = 0;
      for (int i = 1; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) m = i;
      return m;
   endfunction

   // expected outputs depend only on edges since reset, captured value and halt
   task automatic step();
      logic [7:0] ea;
      logic [6:0] es;
      logic ed, bl;
      logic [3:0] nb;
      int ix;
      if (rst) begin
         ea = 8'hFF; es = 7'h7F; ed = 1'b1;
      end else begin
         ix = (k / D) % 8;
         bl = 1'b0;
`ifdef SEG_LEAD_BLANK_EN
         bl = ix > top_nz(disp_m);
`endif
         nb = disp_m[4*ix +: 4];
         ea = bl ? 8'hFF : ~(8'd1 << ix);
         es = bl ? 7'h7F : dec_tab[nb];
         ed = bl | ~halt_m;
      end
      if (rst) begin
         k = 0; disp_m = '0; halt_m = 1'b0;
      end else begin
         if (en && !halt_m) disp_m = display;
         if (halt) halt_m = 1'b1;
         k++;
      end
      @(posedge clk);
      #1;
      chk("an_n", an_n, ea);
      chk("seg_n", {1'b0, seg_n}, {1'b0, es});
      chk("dp_n", {7'b0, dp_n}, {7'b0, ed});
   endtask

   initial begin
      int n;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      en = 1'b1;
      display = 32'h01234567;
      for (int i = 0; i < 40; i++) step();
      display = 32'h0000000F;
      step();
      en = 1'b0;
      display = 32'h00000001;
      for (int i = 0; i < 8 * D; i++) step();
      for (int i = 0; i < 200; i++) begin
         en = $urandom_range(0, 1) == 1;
         display = $urandom;
         step();
      end
      halt = 1'b1;
      en = 1'b1;
      display = 32'hDEADBEEF;
      step();
      halt = 1'b0;
      display = 32'h0;
      for (int i = 0; i < 40; i++) step();
      chk("halt_dp", {7'b0, dp_n}, 8'h00);
      n = 0;
      while (((k / D) % 8) != 5 && n < 8 * D) begin
         step();
         n++;
      end
      chk("idx5_reached", 8'(((k / D) % 8)), 8'd5);
      rst = 1'b1;
      step();
      chk("rst_dp", {7'b0, dp_n}, 8'h01);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) step();
      for (int i = 0; i < 400; i++) begin
         rst = $urandom_range(0, 99) == 0;
         halt = $urandom_range(0, 63) == 0;
         en = $urandom_range(0, 3) != 0;
         display = $urandom >> $urandom_range(0, 32);
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
